tt_dec_eval: RTL and testbench
==============================

Name: tt_dec_eval

Overview:
Parametrised, registered successor to the 2x4 negative-enable decoder-tree function evaluator.
- Decodes an N_IN-bit input vector into a one-hot minterm vector.
- Evaluates a Boolean function F held as a runtime-programmable minterm mask instead of fixed OR wiring.
- Adds serial mask programming and a self-sweep mode that counts the function's minterms.
- Sits as a reusable logic-function block alongside the existing decoder primitives.

Parameters:
N_IN, 4, number of function inputs; legal 2..6; MASK_W = 2**N_IN (derived, not overridable)
DEF_MASK, 16'h0DE0, reset value of the active mask, MASK_W bits; bit k = 1 means minterm k is in F (default Σm(5,6,7,8,10,11))

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  synchronous, active-low reset
en_n  in  1  negative enable for the evaluation path; 0 = enabled
in_valid  in  1  in_vec qualifier
in_vec  in  N_IN  function inputs; MSB = A
out_valid  out  1  onehot/f valid
onehot  out  MASK_W  registered decoder output; bit k set when in_vec == k
f  out  1  registered F(in_vec)
prog_start  in  1  pulse; begin mask load
prog_valid  in  1  prog_bit qualifier
prog_bit  in  1  serial mask bit, minterm 0 first
prog_busy  out  1  high in PROG
prog_done  out  1  1-cycle pulse on mask commit
sweep_start  in  1  pulse; begin minterm count
sweep_busy  out  1  high in SWEEP
sweep_done  out  1  1-cycle pulse at sweep end
sweep_count  out  N_IN+1  number of set bits in active mask

Behaviour:
Reset (rst_n = 0 at an edge):
- state = IDLE; active mask = DEF_MASK; shadow mask = 0; bit index = 0.
- All outputs = 0, including sweep_count.
- Reset mid-PROG discards the partial load; reset mid-SWEEP discards the partial count.

FSM states: IDLE, PROG, SWEEP.

IDLE evaluation path:
- Condition: in_valid = 1 and en_n = 0 at edge t.
- At t+1: out_valid = 1, onehot = (1 << in_vec), f = mask[in_vec].
- Otherwise at t+1: out_valid = 0, onehot = 0, f = 0.
- en_n = 1 forces all-zero outputs regardless of in_valid, matching the existing decoder's default case.
- Throughput: one result per cycle; back-to-back in_valid is legal.

Outside IDLE:
- in_valid is ignored.
- out_valid, onehot and f are 0.

Transitions out of IDLE:
- prog_start -> PROG: index cleared, shadow cleared.
- sweep_start -> SWEEP: index cleared, counter cleared.
- prog_start and sweep_start in the same cycle: PROG wins; the sweep request is dropped.

PROG:
- Each cycle with prog_valid = 1: shadow[index] = prog_bit, index += 1.
- Cycles with prog_valid = 0 are stalls with no timeout.
- On the cycle the bit at index MASK_W-1 is accepted:
  - active mask <= shadow with the final bit included, committed atomically;
  - prog_done pulses the next cycle;
  - state returns to IDLE.
- prog_start during PROG restarts the load: index = 0, shadow cleared.
- sweep_start during PROG is ignored.
- The active mask never changes before commit.

SWEEP:
- One minterm per cycle, index 0..MASK_W-1; counter += mask[index].
- After index MASK_W-1, sweep_count <= final count, then:
  - sweep_done pulses;
  - state returns to IDLE.
- Total duration: MASK_W+1 cycles from the sweep_start edge to sweep_done.
- sweep_count holds its value until the next sweep completes.
- prog_start and sweep_start during SWEEP are ignored.

Width rules:
- The index counter is N_IN+1 bits wide and wraps to 0 on return to IDLE.
- sweep_count is wide enough for MASK_W, e.g. an all-ones mask with N_IN=4 gives 16 = 5'b10000.

Test Plan:
1. Reset, en_n=0, stream in_vec 0..15 with in_valid held high -> each result 1 cycle later; f=1 only for 5,6,7,8,10,11; onehot = 1<<in_vec.
2. en_n=1 with in_valid=1 and in_vec=5 -> out_valid=0, onehot=0, f=0; drop en_n to 0 -> next cycle f=1.
3. Program mask 16'h8001 with bits LSB first and two stall cycles inserted -> prog_done pulses exactly once after the 16th bit. Before commit, in_vec=5 gives f=1; after commit, in_vec=0 and in_vec=15 give f=1 and in_vec=5 gives f=0.
4. Sweep with the default mask -> sweep_done 17 cycles after sweep_start, sweep_count=6. Program 16'hFFFF and sweep again -> sweep_count=16.
5. Assert prog_start and sweep_start in the same IDLE cycle -> prog_busy=1, sweep_busy=0. Send 7 bits, pulse prog_start again, then send 16 bits of 16'h00F0 -> mask = 16'h00F0.
6. Assert rst_n=0 after 10 bits of a PROG load, and separately mid-SWEEP -> mask = 16'h0DE0, all outputs 0, state IDLE on the cycle after reset.

Source files
------------

// File: rtl/tt_dec_eval.sv
// Registered decoder-tree function evaluator: one-hot minterm decode of in_vec plus
// F(in_vec) from a runtime-programmable minterm mask, with serial mask load and minterm-count sweep.
module tt_dec_eval #(
  parameter int N_IN = 4,
  parameter logic [(2**N_IN)-1:0] DEF_MASK = 16'h0DE0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_n,
  input  logic                     in_valid,
  input  logic [N_IN-1:0]          in_vec,
  output logic                     out_valid,
  output logic [(2**N_IN)-1:0]     onehot,
  output logic                     f,
  input  logic                     prog_start,
  input  logic                     prog_valid,
  input  logic                     prog_bit,
  output logic                     prog_busy,
  output logic                     prog_done,
  input  logic                     sweep_start,
  output logic                     sweep_busy,
  output logic                     sweep_done,
  output logic [N_IN:0]            sweep_count
);

  localparam int MASK_W = 2**N_IN;
  localparam logic [N_IN:0] IDX_LAST = (N_IN+1)'(MASK_W - 1);
  localparam logic [N_IN:0] IDX_END  = (N_IN+1)'(MASK_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROG  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [MASK_W-1:0]   mask_r, mask_s;
  logic [MASK_W-1:0]   shadow_r, shadow_s;
  logic [N_IN:0]       idx_r, idx_s;
  logic [N_IN:0]       cnt_r, cnt_s;
  logic [N_IN:0]       sweep_count_r, sweep_count_s;
  logic                out_valid_r, out_valid_s;
  logic [MASK_W-1:0]   onehot_r, onehot_s;
  logic                f_r, f_s;
  logic                prog_busy_r, prog_busy_s;
  logic                prog_done_r, prog_done_s;
  logic                sweep_busy_r, sweep_busy_s;
  logic                sweep_done_r, sweep_done_s;

  // Next-state, mask/shadow/counter updates and next output values
  always_comb begin
    state_s       = state_r;
    mask_s        = mask_r;
    shadow_s      = shadow_r;
    idx_s         = idx_r;
    cnt_s         = cnt_r;
    sweep_count_s = sweep_count_r;
    out_valid_s   = 1'b0;
    onehot_s      = {MASK_W{1'b0}};
    f_s           = 1'b0;
    prog_done_s   = 1'b0;
    sweep_done_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (in_valid && !en_n) begin
          out_valid_s = 1'b1;
          onehot_s    = {{(MASK_W-1){1'b0}}, 1'b1} << in_vec;
          f_s         = mask_r[in_vec];
        end else begin
          out_valid_s = 1'b0;
          onehot_s    = {MASK_W{1'b0}};
          f_s         = 1'b0;
        end
        // A simultaneous sweep request is dropped in favour of programming
        if (prog_start) begin
          state_s  = PROG;
          idx_s    = {(N_IN+1){1'b0}};
          shadow_s = {MASK_W{1'b0}};
        end else if (sweep_start) begin
          state_s = SWEEP;
          idx_s   = {(N_IN+1){1'b0}};
          cnt_s   = {(N_IN+1){1'b0}};
        end else begin
          idx_s = {(N_IN+1){1'b0}};
        end
      end
      PROG: begin
        if (prog_start) begin
          idx_s    = {(N_IN+1){1'b0}};
          shadow_s = {MASK_W{1'b0}};
        end else if (prog_valid) begin
          shadow_s[idx_r[N_IN-1:0]] = prog_bit;
          if (idx_r == IDX_LAST) begin
            mask_s      = shadow_s;
            prog_done_s = 1'b1;
            state_s     = IDLE;
            idx_s       = {(N_IN+1){1'b0}};
          end else begin
            idx_s = idx_r + {{N_IN{1'b0}}, 1'b1};
          end
        end else begin
          idx_s = idx_r;
        end
      end
      SWEEP: begin
        // Index runs one past the last minterm so the final count lands a cycle later
        if (idx_r == IDX_END) begin
          sweep_count_s = cnt_r;
          sweep_done_s  = 1'b1;
          state_s       = IDLE;
          idx_s         = {(N_IN+1){1'b0}};
        end else begin
          cnt_s = cnt_r + {{N_IN{1'b0}}, mask_r[idx_r[N_IN-1:0]]};
          idx_s = idx_r + {{N_IN{1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = {(N_IN+1){1'b0}};
      end
    endcase

    prog_busy_s  = (state_s == PROG);
    sweep_busy_s = (state_s == SWEEP);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      mask_r        <= DEF_MASK;
      shadow_r      <= {MASK_W{1'b0}};
      idx_r         <= {(N_IN+1){1'b0}};
      cnt_r         <= {(N_IN+1){1'b0}};
      sweep_count_r <= {(N_IN+1){1'b0}};
      out_valid_r   <= 1'b0;
      onehot_r      <= {MASK_W{1'b0}};
      f_r           <= 1'b0;
      prog_busy_r   <= 1'b0;
      prog_done_r   <= 1'b0;
      sweep_busy_r  <= 1'b0;
      sweep_done_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      mask_r        <= mask_s;
      shadow_r      <= shadow_s;
      idx_r         <= idx_s;
      cnt_r         <= cnt_s;
      sweep_count_r <= sweep_count_s;
      out_valid_r   <= out_valid_s;
      onehot_r      <= onehot_s;
      f_r           <= f_s;
      prog_busy_r   <= prog_busy_s;
      prog_done_r   <= prog_done_s;
      sweep_busy_r  <= sweep_busy_s;
      sweep_done_r  <= sweep_done_s;
    end
  end

  assign out_valid   = out_valid_r;
  assign onehot      = onehot_r;
  assign f           = f_r;
  assign prog_busy   = prog_busy_r;
  assign prog_done   = prog_done_r;
  assign sweep_busy  = sweep_busy_r;
  assign sweep_done  = sweep_done_r;
  assign sweep_count = sweep_count_r;

endmodule

// File: tb/tb_tt_dec_eval.sv
// Directed self-checking bench for tt_dec_eval (N_IN=4): evaluation, enable gating,
// serial programming with stalls/restart, sweep latency and count, reset mid-operation.
module tb_tt_dec_eval;

  logic        clk;
  logic        rst_n;
  logic        en_n;
  logic        in_valid;
  logic [3:0]  in_vec;
  logic        out_valid;
  logic [15:0] onehot;
  logic        f;
  logic        prog_start;
  logic        prog_valid;
  logic        prog_bit;
  logic        prog_busy;
  logic        prog_done;
  logic        sweep_start;
  logic        sweep_busy;
  logic        sweep_done;
  logic [4:0]  sweep_count;

  int checks;
  int failures;

  tt_dec_eval #(.N_IN(4), .DEF_MASK(16'h0DE0)) dut (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .in_valid(in_valid), .in_vec(in_vec),
    .out_valid(out_valid), .onehot(onehot), .f(f),
    .prog_start(prog_start), .prog_valid(prog_valid), .prog_bit(prog_bit),
    .prog_busy(prog_busy), .prog_done(prog_done),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .sweep_count(sweep_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_onehot"}, {16'd0, onehot}, 32'd0);
    chk({tag, "_f"}, {31'd0, f}, 32'd0);
    chk({tag, "_prog_busy"}, {31'd0, prog_busy}, 32'd0);
    chk({tag, "_prog_done"}, {31'd0, prog_done}, 32'd0);
    chk({tag, "_sweep_busy"}, {31'd0, sweep_busy}, 32'd0);
    chk({tag, "_sweep_done"}, {31'd0, sweep_done}, 32'd0);
    chk({tag, "_sweep_count"}, {27'd0, sweep_count}, 32'd0);
  endtask

  task automatic eval(input logic [3:0] k, input logic exp_f);
    logic [15:0] oh;
    oh = 16'h0001 << k;
    en_n = 1'b0;
    in_valid = 1'b1;
    in_vec = k;
    tick();
    in_valid = 1'b0;
    chk($sformatf("eval%0d_valid", k), {31'd0, out_valid}, 32'd1);
    chk($sformatf("eval%0d_onehot", k), {16'd0, onehot}, {16'd0, oh});
    chk($sformatf("eval%0d_f", k), {31'd0, f}, {31'd0, exp_f});
  endtask

  task automatic send_bits(input logic [15:0] val, input int nbits, input logic stall,
                           input logic last_commits);
    for (int i = 0; i < nbits; i++) begin
      if (stall && (i == 4 || i == 10)) begin
        prog_valid = 1'b0;
        tick();
        chk("prog_stall_done", {31'd0, prog_done}, 32'd0);
        chk("prog_stall_busy", {31'd0, prog_busy}, 32'd1);
      end
      prog_valid = 1'b1;
      prog_bit = val[i];
      tick();
      chk($sformatf("prog_done_bit%0d", i), {31'd0, prog_done},
          {31'd0, (last_commits && i == nbits - 1)});
    end
    prog_valid = 1'b0;
  endtask

  task automatic prog_mask(input logic [15:0] val, input logic stall);
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    chk("prog_busy_start", {31'd0, prog_busy}, 32'd1);
    send_bits(val, 16, stall, 1'b1);
    chk("prog_busy_end", {31'd0, prog_busy}, 32'd0);
    tick();
    chk("prog_done_pulse_end", {31'd0, prog_done}, 32'd0);
  endtask

  task automatic sweep_run(input logic [4:0] exp_cnt);
    int  n;
    logic done;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk("sweep_busy_start", {31'd0, sweep_busy}, 32'd1);
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (sweep_done) done = 1'b1;
    end
    chk("sweep_latency", n, 32'd17);
    chk("sweep_count", {27'd0, sweep_count}, {27'd0, exp_cnt});
    chk("sweep_busy_end", {31'd0, sweep_busy}, 32'd0);
    tick();
    chk("sweep_done_pulse_end", {31'd0, sweep_done}, 32'd0);
    chk("sweep_count_hold", {27'd0, sweep_count}, {27'd0, exp_cnt});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] def_mask;
    logic [15:0] m00f0;
    checks = 0;
    failures = 0;
    def_mask = 16'h0DE0;
    m00f0 = 16'h00F0;
    rst_n = 1'b0;
    en_n = 1'b1;
    in_valid = 1'b0;
    in_vec = 4'd0;
    prog_start = 1'b0;
    prog_valid = 1'b0;
    prog_bit = 1'b0;
    sweep_start = 1'b0;

    // Reset state
    tick();
    tick();
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    // Streamed evaluation with the default mask, back-to-back
    en_n = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_vec = 4'(k);
      tick();
      chk($sformatf("stream%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream%0d_onehot", k), {16'd0, onehot}, 32'd1 << k);
      chk($sformatf("stream%0d_f", k), {31'd0, f}, {31'd0, def_mask[k]});
    end
    in_valid = 1'b0;
    tick();
    chk("stream_idle_valid", {31'd0, out_valid}, 32'd0);

    // Negative enable gating
    en_n = 1'b1;
    in_valid = 1'b1;
    in_vec = 4'd5;
    tick();
    chk("en_off_valid", {31'd0, out_valid}, 32'd0);
    chk("en_off_onehot", {16'd0, onehot}, 32'd0);
    chk("en_off_f", {31'd0, f}, 32'd0);
    en_n = 1'b0;
    tick();
    chk("en_on_f", {31'd0, f}, 32'd1);
    chk("en_on_onehot", {16'd0, onehot}, 32'h0020);
    in_valid = 1'b0;

    // Sweep of the default mask
    sweep_run(5'd6);

    // Program 16'h8001 with stalls; mask unchanged before commit
    eval(4'd5, 1'b1);
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    in_valid = 1'b1;
    in_vec = 4'd5;
    send_bits(16'h8001, 16, 1'b1, 1'b1);
    chk("prog_in_valid_ignored", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("prog_done_once", {31'd0, prog_done}, 32'd0);
    eval(4'd0, 1'b1);
    eval(4'd15, 1'b1);
    eval(4'd5, 1'b0);
    sweep_run(5'd2);

    // All-ones mask counts to MASK_W
    prog_mask(16'hFFFF, 1'b0);
    sweep_run(5'd16);

    // Simultaneous start, partial load, restart, full load of 16'h00F0
    prog_start = 1'b1;
    sweep_start = 1'b1;
    tick();
    prog_start = 1'b0;
    sweep_start = 1'b0;
    chk("both_start_prog_busy", {31'd0, prog_busy}, 32'd1);
    chk("both_start_sweep_busy", {31'd0, sweep_busy}, 32'd0);
    send_bits(16'h0055, 7, 1'b0, 1'b0);
    prog_start = 1'b1;
    sweep_start = 1'b1;
    tick();
    prog_start = 1'b0;
    sweep_start = 1'b0;
    chk("restart_prog_busy", {31'd0, prog_busy}, 32'd1);
    chk("restart_sweep_busy", {31'd0, sweep_busy}, 32'd0);
    send_bits(m00f0, 16, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 16; k++) eval(4'(k), m00f0[k]);
    sweep_run(5'd4);

    // Reset mid-PROG discards the partial load
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    send_bits(16'hFFFF, 10, 1'b0, 1'b0);
    prog_valid = 1'b1;
    do_reset();
    prog_valid = 1'b0;
    chk_idle_outputs("rst_prog");
    for (int i = 0; i < 8; i++) tick();
    chk("rst_prog_no_done", {31'd0, prog_done}, 32'd0);
    eval(4'd5, 1'b1);
    eval(4'd4, 1'b0);
    eval(4'd8, 1'b1);

    // Reset mid-SWEEP discards the partial count
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    in_valid = 1'b1;
    in_vec = 4'd6;
    for (int i = 0; i < 8; i++) tick();
    chk("sweep_in_valid_ignored", {31'd0, out_valid}, 32'd0);
    chk("sweep_mid_count_hold", {27'd0, sweep_count}, 32'd0);
    in_valid = 1'b0;
    do_reset();
    chk_idle_outputs("rst_sweep");
    for (int i = 0; i < 12; i++) tick();
    chk("rst_sweep_no_done", {31'd0, sweep_done}, 32'd0);
    eval(4'd0, 1'b0);
    eval(4'd11, 1'b1);
    sweep_run(5'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
